// File: rtl/mux2_rr_arbiter_if.sv
// rtl/mux2_rr_arbiter_if.sv - requester/arbiter bundle for the shared 2:1 mux
interface mux2_rr_arbiter_if #(
   parameter int DATA_W = 8
);
   logic              req0;
   logic              req1;
   logic [DATA_W-1:0] d0;
   logic [DATA_W-1:0] d1;
   logic              gnt0;
   logic              gnt1;
   logic              s;
   logic [DATA_W-1:0] y;
   logic              y_valid;

   modport master (
      output req0, req1, d0, d1,
      input  gnt0, gnt1, s, y, y_valid
   );

   modport slave (
      input  req0, req1, d0, d1,
      output gnt0, gnt1, s, y, y_valid
   );
endinterface

// File: rtl/mux2_rr_arbiter.sv
// rtl/mux2_rr_arbiter.sv - round-robin owner of a 2:1 mux with bounded hold and registered output
module mux2_rr_arbiter #(
   parameter int DATA_W   = 8,
   parameter int MAX_HOLD = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   mux2_rr_arbiter_if.slave   bus
);
   localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam logic [CW-1:0] CMAX = CW'(MAX_HOLD - 1);

   typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

   state_t            state;
   state_t            nxt;
   logic              last;
   logic [CW-1:0]     cnt;
   logic              gnt0_r;
   logic              gnt1_r;
   logic              s_r;
   logic [DATA_W-1:0] y_r;
   logic              y_valid_r;
   logic              take;

   assign bus.gnt0    = gnt0_r;
   assign bus.gnt1    = gnt1_r;
   assign bus.s       = s_r;
   assign bus.y       = y_r;
   assign bus.y_valid = y_valid_r;

   assign take = (gnt0_r & bus.req0) | (gnt1_r & bus.req1);

   always_comb begin
      nxt = state;
      case (state)
         IDLE: begin
            if (bus.req0 && bus.req1) nxt = last ? OWN0 : OWN1;
            else if (bus.req0)        nxt = OWN0;
            else if (bus.req1)        nxt = OWN1;
         end
         OWN0: begin
            if (!bus.req0)                   nxt = bus.req1 ? OWN1 : IDLE;
            else if (bus.req1 && cnt == CMAX) nxt = OWN1;
         end
         OWN1: begin
            if (!bus.req1)                   nxt = bus.req0 ? OWN0 : IDLE;
            else if (bus.req0 && cnt == CMAX) nxt = OWN0;
         end
         default: nxt = IDLE;
      endcase
   end

   // Grants and select are registered copies of the next state; s keeps its value through IDLE.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         last      <= 1'b1;
         cnt       <= '0;
         gnt0_r    <= 1'b0;
         gnt1_r    <= 1'b0;
         s_r       <= 1'b0;
         y_r       <= '0;
         y_valid_r <= 1'b0;
      end else begin
         state     <= nxt;
         gnt0_r    <= (nxt == OWN0);
         gnt1_r    <= (nxt == OWN1);
         y_valid_r <= take;
         if (take) y_r <= s_r ? bus.d1 : bus.d0;
         if (nxt != IDLE) s_r <= (nxt == OWN1);
         if (nxt == IDLE || nxt != state) begin
            cnt <= '0;
         end else if (cnt != CMAX) begin
            cnt <= cnt + 1'b1;
         end
         if (nxt != IDLE && nxt != state) last <= (nxt == OWN1);
      end
   end
endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// tb/tb_mux2_rr_arbiter.sv - directed vector bench for mux2_rr_arbiter
module tb_mux2_rr_arbiter;
   logic clk = 1'b0;
   logic rst_n;
   int   n_tests = 0;
   int   n_fail  = 0;

   mux2_rr_arbiter_if #(.DATA_W(8)) bus ();

   mux2_rr_arbiter #(.DATA_W(8), .MAX_HOLD(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst_n;
      logic       req0;
      logic       req1;
      logic [7:0] d0;
      logic [7:0] d1;
      logic       g0;
      logic       g1;
      logic       s;
      logic [7:0] y;
      logic       yv;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(logic r, logic q0, logic q1, logic [7:0] a, logic [7:0] b,
                               logic g0, logic g1, logic s, logic [7:0] y, logic yv);
      vec_t v;
      v.rst_n = r; v.req0 = q0; v.req1 = q1; v.d0 = a; v.d1 = b;
      v.g0 = g0; v.g1 = g1; v.s = s; v.y = y; v.yv = yv;
      return v;
   endfunction

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic q0, input logic q1,
                        input logic [7:0] a, input logic [7:0] b);
      rst_n = r; bus.req0 = q0; bus.req1 = q1; bus.d0 = a; bus.d1 = b;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string tag, input logic g0, input logic g1, input logic s,
                            input logic [7:0] y, input logic yv);
      check({tag, ".gnt0"},    8'(bus.gnt0),    8'(g0));
      check({tag, ".gnt1"},    8'(bus.gnt1),    8'(g1));
      check({tag, ".s"},       8'(bus.s),       8'(s));
      check({tag, ".y"},       bus.y,           y);
      check({tag, ".y_valid"}, 8'(bus.y_valid), 8'(yv));
   endtask

   initial begin
      logic pg0, pg1, pq0, pq1, ps, got;
      drive(1'b0, 1'b1, 1'b1, 8'h11, 8'h22);

      // reset, fairness, handover, idle return, lone requester
      tbl.push_back(mk(0,1,1,8'h11,8'h22, 0,0,0,8'h00,0));
      tbl.push_back(mk(0,1,1,8'h11,8'h22, 0,0,0,8'h00,0));
      tbl.push_back(mk(1,1,1,8'h11,8'h22, 1,0,0,8'h00,0));
      tbl.push_back(mk(1,1,1,8'h11,8'h22, 1,0,0,8'h11,1));
      tbl.push_back(mk(1,1,1,8'h11,8'h22, 1,0,0,8'h11,1));
      tbl.push_back(mk(1,1,1,8'h11,8'h22, 1,0,0,8'h11,1));
      tbl.push_back(mk(1,1,1,8'h11,8'h22, 0,1,1,8'h11,1));
      tbl.push_back(mk(1,1,1,8'h11,8'h22, 0,1,1,8'h22,1));
      tbl.push_back(mk(1,1,1,8'h11,8'h22, 0,1,1,8'h22,1));
      tbl.push_back(mk(1,1,1,8'h11,8'h22, 0,1,1,8'h22,1));
      tbl.push_back(mk(1,1,1,8'h11,8'h22, 1,0,0,8'h22,1));
      tbl.push_back(mk(1,1,1,8'h11,8'h22, 1,0,0,8'h11,1));
      tbl.push_back(mk(1,0,1,8'h33,8'h22, 0,1,1,8'h11,0));
      tbl.push_back(mk(1,0,1,8'h33,8'h44, 0,1,1,8'h44,1));
      tbl.push_back(mk(1,0,0,8'h33,8'h44, 0,0,1,8'h44,0));
      tbl.push_back(mk(1,0,0,8'h33,8'h44, 0,0,1,8'h44,0));
      tbl.push_back(mk(1,1,1,8'h33,8'h44, 1,0,0,8'h44,0));
      tbl.push_back(mk(1,0,1,8'h33,8'hA5, 0,1,1,8'h44,0));
      for (int i = 0; i < 9; i++)
         tbl.push_back(mk(1,0,1,8'h33,8'hA5, 0,1,1,8'hA5,1));

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].rst_n, tbl[i].req0, tbl[i].req1, tbl[i].d0, tbl[i].d1);
         tick();
         check_all($sformatf("vec%0d", i), tbl[i].g0, tbl[i].g1, tbl[i].s, tbl[i].y, tbl[i].yv);
      end

      // reset while port 1 holds the grant with cnt=2
      drive(1, 0, 0, 8'h33, 8'h5A); tick();
      check_all("t6.idle", 0, 0, 1, 8'hA5, 0);
      drive(1, 0, 1, 8'h33, 8'h5A); tick();
      check_all("t6.own1", 0, 1, 1, 8'hA5, 0);
      tick();
      check_all("t6.cnt1", 0, 1, 1, 8'h5A, 1);
      tick();
      check_all("t6.cnt2", 0, 1, 1, 8'h5A, 1);
      drive(0, 1, 1, 8'h77, 8'h5A); tick();
      check_all("t6.rst", 0, 0, 0, 8'h00, 0);
      drive(1, 1, 1, 8'h77, 8'h5A); tick();
      check_all("t6.own0", 1, 0, 0, 8'h00, 0);
      tick();
      check_all("t6.data", 1, 0, 0, 8'h77, 1);

      // bounded wait for handover to a lone port-1 request
      drive(1, 0, 1, 8'h77, 8'h66);
      got = 1'b0;
      for (int c = 0; c < 8 && !got; c++) begin
         tick();
         got = bus.gnt1;
      end
      check("handover_timeout", 8'(got), 8'h01);

      // random requests: exclusive grants, select follows owner, y_valid tracks prior grant
      pg0 = bus.gnt0; pg1 = bus.gnt1; pq0 = bus.req0; pq1 = bus.req1; ps = bus.s;
      for (int c = 0; c < 200; c++) begin
         drive(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               8'($urandom), 8'($urandom));
         pq0 = bus.req0; pq1 = bus.req1;
         tick();
         check("rnd.excl", 8'(bus.gnt0 & bus.gnt1), 8'h00);
         if (bus.gnt0 || bus.gnt1) check("rnd.s", 8'(bus.s), 8'(bus.gnt1));
         else                      check("rnd.s_hold", 8'(bus.s), 8'(ps));
         check("rnd.yv", 8'(bus.y_valid), 8'((pg0 & pq0) | (pg1 & pq1)));
         pg0 = bus.gnt0; pg1 = bus.gnt1; ps = bus.s;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
